systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 13 +
 rtl/systolic_feeder_if.sv | 46 ++++
 rtl/systolic_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types and defaults for the systolic-array feeder: lane width and the
// broadcast PE mode encoding.
package systolic_feeder_pkg;

  localparam int unsigned NUM_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    PASSTHROUGH = 2'd0,
    LOAD        = 2'd1,
    PROCESS     = 2'd2
  } input_mux_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and array-edge bundle between a job source and the systolic feeder.
// stall_cnt_o exists only when FEEDER_PERF_EN is defined.
interface systolic_feeder_if #(
  parameter int unsigned NUM_BITS = systolic_feeder_pkg::NUM_BITS_DEFAULT,
  parameter int unsigned DIM      = 4
);

  logic                              start_i;
  logic                              reuse_i;
  logic                              w_valid_i;
  logic                              w_ready_o;
  logic [DIM*NUM_BITS-1:0]           w_row_i;
  logic                              a_valid_i;
  logic                              a_ready_o;
  logic [DIM*NUM_BITS-1:0]           a_vec_i;
  logic                              a_last_i;
  logic [DIM*NUM_BITS-1:0]           top_o;
  logic [DIM*NUM_BITS-1:0]           left_o;
  systolic_feeder_pkg::input_mux_t   mux_o;
  logic                              add_zero_o;
  logic [DIM-1:0]                    out_valid_o;
  logic                              busy_o;
  logic                              done_o;
`ifdef FEEDER_PERF_EN
  logic [15:0]                       stall_cnt_o;
`endif

  modport slave (
    input  start_i, reuse_i, w_valid_i, w_row_i, a_valid_i, a_vec_i, a_last_i,
    output w_ready_o, a_ready_o, top_o, left_o, mux_o, add_zero_o,
           out_valid_o, busy_o, done_o
`ifdef FEEDER_PERF_EN
    , output stall_cnt_o
`endif
  );

  modport master (
    output start_i, reuse_i, w_valid_i, w_row_i, a_valid_i, a_vec_i, a_last_i,
    input  w_ready_o, a_ready_o, top_o, left_o, mux_o, add_zero_o,
           out_valid_o, busy_o, done_o
`ifdef FEEDER_PERF_EN
    , input stall_cnt_o
`endif
  );

endinterface

// File: rtl/systolic_feeder.sv
// Feeds a DIM x DIM weight-stationary systolic array: loads weight rows, then
// skews activation vectors onto the left edge. Optional macro: FEEDER_PERF_EN.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned NUM_BITS = NUM_BITS_DEFAULT,
  parameter int unsigned DIM      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  systolic_feeder_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(DIM) + 1;
  localparam int unsigned VLD_DEPTH = 2 * DIM - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * DIM - 2);

  logic [1:0]                         r_state;
  logic [1:0]                         w_state_nxt;
  logic [CNT_W-1:0]                   r_cnt;
  logic                               r_done;
  logic [VLD_DEPTH-1:0]               r_vld_sr;
  logic                               w_w_acc;
  logic                               w_a_acc;
  logic                               w_last_row;
  logic                               w_drain_end;
  logic [DIM-1:0][NUM_BITS-1:0]       w_lane_in;
  logic [DIM-1:0][NUM_BITS-1:0]       w_left;

  assign w_w_acc     = (r_state == ST_LOAD) && bus.w_valid_i;
  assign w_a_acc     = (r_state == ST_STREAM) && bus.a_valid_i;
  assign w_last_row  = (r_cnt == LAST_ROW);
  assign w_drain_end = (r_state == ST_DRAIN) && (r_cnt == DRAIN_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start_i) w_state_nxt = bus.reuse_i ? ST_STREAM : ST_LOAD;
      ST_LOAD:   if (w_w_acc && w_last_row) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_a_acc && bus.a_last_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_drain_end) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // r_cnt counts accepted rows in LOAD and elapsed cycles in DRAIN.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_drain_end;
      if (r_state != w_state_nxt) r_cnt <= '0;
      else if (w_w_acc || (r_state == ST_DRAIN)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.w_ready_o  = (r_state == ST_LOAD);
    bus.a_ready_o  = (r_state == ST_STREAM);
    bus.busy_o     = (r_state != ST_IDLE);
    bus.done_o     = r_done;
    bus.add_zero_o = 1'b1;
    bus.top_o      = w_w_acc ? bus.w_row_i : '0;
    bus.mux_o      = PROCESS;
    // A LOAD stall keeps mux at LOAD with a zero top so the bottom chain holds.
    if (r_state == ST_LOAD)
      bus.mux_o = (w_w_acc && !w_last_row) ? PASSTHROUGH : LOAD;
  end

  // Bubbles and non-STREAM cycles inject zero so they travel like data.
  always_comb begin
    for (int r = 0; r < DIM; r++)
      w_lane_in[r] = w_a_acc ? bus.a_vec_i[r*NUM_BITS +: NUM_BITS] : '0;
  end

  assign w_left[0] = w_lane_in[0];

  for (genvar r = 1; r < DIM; r++) begin : g_skew
    logic [NUM_BITS-1:0] r_dly [r];

    // NOTE: skew stages are reset like any other state; stale lanes would leak onto left_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int k = 0; k < r; k++) r_dly[k] <= '0;
      end else begin
        r_dly[0] <= w_lane_in[r];
        for (int k = 1; k < r; k++) r_dly[k] <= r_dly[k-1];
      end
    end

    assign w_left[r] = r_dly[r-1];
  end

  assign bus.left_o = w_left;

  // Acceptance history: bit k means a vector was accepted k+1 cycles ago.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= w_a_acc;
      for (int k = 1; k < VLD_DEPTH; k++) r_vld_sr[k] <= r_vld_sr[k-1];
    end
  end

  assign bus.out_valid_o = r_vld_sr[VLD_DEPTH-1 -: DIM];

`ifdef FEEDER_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && bus.start_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_STREAM) && !bus.a_valid_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
`endif

endmodule
